decode_unit: RTL and testbench

Instruction decode stage of the 16-bit RISC pipeline, directly upstream of the 8×16 register file. It takes instruction words from the IF/ID buffer and drives the register file read port (addresses and read enable). It captures the operands the file returns on the falling edge and loads a registered ID/EX bundle of operands and control for execute. It also assembles two-word (immediate) instructions, inserts a load-use bubble, and honours downstream stall and branch flush.

---
 rtl/decode_unit_if.sv | 61 ++++++
 rtl/decode_unit.sv | 208 ++++++++++++++++++++
 tb/tb_decode_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_unit_if.sv
// ---------------------------------------------------------------------------
// decode_unit_if
//   Signal bundle between the decode stage and its neighbours: the IF/ID
//   word handshake, the flush/stall controls from execute, the register-file
//   read port and the registered ID/EX bundle.
//
//   Handshake: a word transfers on a rising clk edge where
//   if_valid && if_ready. if_valid must not depend on if_ready. While
//   if_valid is high and if_ready is low, the producer holds if_instr stable.
//
//   Modports:
//     slave  - the decode stage (decode_unit)
//     master - the surrounding pipeline / testbench
// ---------------------------------------------------------------------------
interface decode_unit_if #(
    parameter int N = 16
);
    // IF/ID word handshake
    logic [N-1:0] if_instr;
    logic         if_valid;
    logic         if_ready;
    // execute-side controls
    logic         flush;
    logic         ex_stall;
    // register-file read port
    logic         rf_read_enable;
    logic [2:0]   rf_read_addr1;
    logic [2:0]   rf_read_addr2;
    logic [N-1:0] rf_read_data1;
    logic [N-1:0] rf_read_data2;
    // ID/EX bundle
    logic         ex_valid;
    logic [4:0]   ex_opcode;
    logic [2:0]   ex_rdst;
    logic [2:0]   ex_rsrc1;
    logic [2:0]   ex_rsrc2;
    logic [N-1:0] ex_op1;
    logic [N-1:0] ex_op2;
    logic [N-1:0] ex_imm;
    logic         ex_use_imm;
    logic         ex_reg_write;
    logic         ex_mem_read;
    logic         ex_mem_write;
    logic         ex_branch;

    modport slave (
        input  if_instr, if_valid, flush, ex_stall, rf_read_data1, rf_read_data2,
        output if_ready, rf_read_enable, rf_read_addr1, rf_read_addr2,
               ex_valid, ex_opcode, ex_rdst, ex_rsrc1, ex_rsrc2,
               ex_op1, ex_op2, ex_imm,
               ex_use_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch
    );

    modport master (
        output if_instr, if_valid, flush, ex_stall, rf_read_data1, rf_read_data2,
        input  if_ready, rf_read_enable, rf_read_addr1, rf_read_addr2,
               ex_valid, ex_opcode, ex_rdst, ex_rsrc1, ex_rsrc2,
               ex_op1, ex_op2, ex_imm,
               ex_use_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch
    );
endinterface

// File: rtl/decode_unit.sv
// ---------------------------------------------------------------------------
// decode_unit
//   Instruction decode stage of the 16-bit RISC pipeline. Decodes words from
//   IF/ID, drives the register-file read port, assembles two-word immediate
//   instructions, inserts a load-use bubble and loads the ID/EX bundle.
//
//   Ports:
//     clk      - pipeline clock, all state on the rising edge
//     rst      - asynchronous active-high reset
//     dif      - decode_unit_if.slave (IF/ID handshake, flush/stall,
//                register-file read port, ID/EX bundle)
//     state_o  - FSM state for observation (0 = DECODE, 1 = IMM_WAIT)
// ---------------------------------------------------------------------------
module decode_unit #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    decode_unit_if.slave dif,
    output logic         state_o
);

    typedef enum logic {
        DECODE   = 1'b0,
        IMM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic         valid;
        logic [4:0]   opcode;
        logic [2:0]   rdst;
        logic [2:0]   rsrc1;
        logic [2:0]   rsrc2;
        logic [N-1:0] op1;
        logic [N-1:0] op2;
        logic [N-1:0] imm;
        logic         use_imm;
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         branch;
    } ex_t;

    typedef struct packed {
        logic uses1;
        logic uses2;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctl_t;

    // Bits [1:0] of an instruction carry nothing, so only [15:2] are decoded
    // and held.
    function automatic ctl_t decode_ctl(input logic [15:2] w);
        ctl_t c;
        c = '0;
        case (w[15:14])
            2'b00: begin
                // opcode 00000 is NOP: issues, but reads and writes nothing
                if (w[15:11] != 5'b00000) begin
                    c.uses1     = 1'b1;
                    c.reg_write = 1'b1;
                end
            end
            2'b01: begin
                c.uses1     = 1'b1;
                c.uses2     = 1'b1;
                c.reg_write = 1'b1;
            end
            2'b10: begin
                case (w[12:11])
                    2'b00: begin
                        c.uses1     = 1'b1;
                        c.reg_write = 1'b1;
                        c.mem_read  = 1'b1;
                    end
                    2'b01: begin
                        c.uses1     = 1'b1;
                        c.uses2     = 1'b1;
                        c.mem_write = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            default: begin
                c.uses1  = 1'b1;
                c.branch = 1'b1;
            end
        endcase
        return c;
    endfunction

    state_t       state_q, state_d;
    logic [15:2]  hold_q, hold_d;
    ex_t          ex_q, ex_d;

    logic [15:2]  cur_w;
    ctl_t         cur_c;
    logic         word_present;
    logic         hazard;
    logic         accept;
    logic         issue;

    // The instruction being decoded: the live word in DECODE, the held first
    // word in IMM_WAIT (while if_instr carries its immediate).
    assign cur_w        = (state_q == IMM_WAIT) ? hold_q : dif.if_instr[15:2];
    assign cur_c        = decode_ctl(cur_w);
    assign word_present = (state_q == IMM_WAIT) | dif.if_valid;

    assign dif.rf_read_addr1  = cur_w[7:5];
    assign dif.rf_read_addr2  = cur_w[4:2];
    assign dif.rf_read_enable = word_present & (cur_c.uses1 | cur_c.uses2);

    // Load in ID/EX whose destination is a source of the live word.
    assign hazard = (state_q == DECODE) & dif.if_valid & ex_q.valid & ex_q.mem_read &
                    ((cur_c.uses1 & (cur_w[7:5] == ex_q.rdst)) |
                     (cur_c.uses2 & (cur_w[4:2] == ex_q.rdst)));

    assign dif.if_ready = ~dif.ex_stall & ~hazard & ~dif.flush;
    assign accept       = dif.if_valid & dif.if_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ex_d    = ex_q;
        issue   = 1'b0;

        // Unless the stage is held by a stall, the bundle defaults to a bubble.
        if (dif.flush | ~dif.ex_stall) begin
            ex_d.valid     = 1'b0;
            ex_d.use_imm   = 1'b0;
            ex_d.reg_write = 1'b0;
            ex_d.mem_read  = 1'b0;
            ex_d.mem_write = 1'b0;
            ex_d.branch    = 1'b0;
        end

        if (dif.flush) begin
            state_d = DECODE;
            hold_d  = '0;
        end else if (!dif.ex_stall) begin
            case (state_q)
                DECODE: begin
                    if (accept) begin
                        if (dif.if_instr[13]) begin
                            hold_d  = dif.if_instr[15:2];
                            state_d = IMM_WAIT;
                        end else begin
                            issue = 1'b1;
                        end
                    end
                end
                IMM_WAIT: begin
                    if (accept) begin
                        issue   = 1'b1;
                        state_d = DECODE;
                    end
                end
            endcase
        end

        if (issue) begin
            ex_d.valid     = 1'b1;
            ex_d.opcode    = cur_w[15:11];
            ex_d.rdst      = cur_w[10:8];
            ex_d.rsrc1     = cur_w[7:5];
            ex_d.rsrc2     = cur_w[4:2];
            // The register file settled these on the preceding falling edge.
            ex_d.op1       = cur_c.uses1 ? dif.rf_read_data1 : '0;
            ex_d.op2       = cur_c.uses2 ? dif.rf_read_data2 : '0;
            ex_d.use_imm   = (state_q == IMM_WAIT);
            ex_d.imm       = (state_q == IMM_WAIT) ? dif.if_instr : '0;
            ex_d.reg_write = cur_c.reg_write;
            ex_d.mem_read  = cur_c.mem_read;
            ex_d.mem_write = cur_c.mem_write;
            ex_d.branch    = cur_c.branch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DECODE;
            hold_q  <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ex_q    <= ex_d;
        end
    end

    assign state_o          = (state_q == IMM_WAIT);
    assign dif.ex_valid     = ex_q.valid;
    assign dif.ex_opcode    = ex_q.opcode;
    assign dif.ex_rdst      = ex_q.rdst;
    assign dif.ex_rsrc1     = ex_q.rsrc1;
    assign dif.ex_rsrc2     = ex_q.rsrc2;
    assign dif.ex_op1       = ex_q.op1;
    assign dif.ex_op2       = ex_q.op2;
    assign dif.ex_imm       = ex_q.imm;
    assign dif.ex_use_imm   = ex_q.use_imm;
    assign dif.ex_reg_write = ex_q.reg_write;
    assign dif.ex_mem_read  = ex_q.mem_read;
    assign dif.ex_mem_write = ex_q.mem_write;
    assign dif.ex_branch    = ex_q.branch;

endmodule

// File: tb/tb_decode_unit.sv
// ---------------------------------------------------------------------------
// tb_decode_unit
//   Directed bench for decode_unit. A small register-file stub answers read
//   addresses on the falling edge. Inputs change 1 time unit after a rising
//   edge; outputs are sampled away from the rising edge.
// ---------------------------------------------------------------------------
module tb_decode_unit;

  logic clk;
  logic rst;
  logic state_dbg;

  int errors;
  int checks;

  logic [15:0] rf [8];

  // {opcode, reg_write, mem_write, branch, op1, op2}
  logic [39:0] exp_q[$];

  decode_unit_if #(.N(16)) dif ();

  decode_unit #(.N(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .dif     (dif),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file stub: data valid after the falling edge
  always @(negedge clk) begin
    dif.rf_read_data1 = rf[dif.rf_read_addr1];
    dif.rf_read_data2 = rf[dif.rf_read_addr2];
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    dif.if_instr = w;
    dif.if_valid = 1'b1;
  endtask

  task automatic idle();
    dif.if_instr = 16'h0000;
    dif.if_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (dif.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", dif.ex_valid); end
    checks++; if (dif.ex_opcode !== 5'h00) begin errors++; $display("FAIL reset_opcode: got %0h expected 0", dif.ex_opcode); end
    checks++; if (dif.ex_op1 !== 16'h0000) begin errors++; $display("FAIL reset_op1: got %0h expected 0", dif.ex_op1); end
    checks++; if (dif.ex_imm !== 16'h0000) begin errors++; $display("FAIL reset_imm: got %0h expected 0", dif.ex_imm); end
    checks++; if (dif.ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %0h expected 0", dif.ex_reg_write); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state: got %0h expected 0", state_dbg); end
    checks++; if (dif.if_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h expected 1", dif.if_ready); end
  endtask

  task automatic test_alu();
    send(16'h4328);
    #1;
    checks++; if (dif.rf_read_addr1 !== 3'd1) begin errors++; $display("FAIL alu_addr1: got %0d expected 1", dif.rf_read_addr1); end
    checks++; if (dif.rf_read_addr2 !== 3'd2) begin errors++; $display("FAIL alu_addr2: got %0d expected 2", dif.rf_read_addr2); end
    checks++; if (dif.rf_read_enable !== 1'b1) begin errors++; $display("FAIL alu_rd_en: got %0h expected 1", dif.rf_read_enable); end
    tick();
    idle();
    checks++; if (dif.ex_valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %0h expected 1", dif.ex_valid); end
    checks++; if (dif.ex_opcode !== 5'h08) begin errors++; $display("FAIL alu_opcode: got %0h expected 08", dif.ex_opcode); end
    checks++; if (dif.ex_rdst !== 3'd3) begin errors++; $display("FAIL alu_rdst: got %0d expected 3", dif.ex_rdst); end
    checks++; if (dif.ex_op1 !== 16'h0005) begin errors++; $display("FAIL alu_op1: got %0h expected 0005", dif.ex_op1); end
    checks++; if (dif.ex_op2 !== 16'h0007) begin errors++; $display("FAIL alu_op2: got %0h expected 0007", dif.ex_op2); end
    checks++; if (dif.ex_reg_write !== 1'b1) begin errors++; $display("FAIL alu_reg_write: got %0h expected 1", dif.ex_reg_write); end
    checks++; if (dif.ex_use_imm !== 1'b0 || dif.ex_imm !== 16'h0000) begin errors++; $display("FAIL alu_no_imm: got use_imm=%0h imm=%0h expected 0/0", dif.ex_use_imm, dif.ex_imm); end
  endtask

  task automatic test_imm();
    send(16'h6120);
    tick();
    send(16'h00FF);
    #1;
    checks++; if (dif.ex_valid !== 1'b0) begin errors++; $display("FAIL imm_gap_valid: got %0h expected 0", dif.ex_valid); end
    checks++; if (state_dbg !== 1'b1) begin errors++; $display("FAIL imm_state_wait: got %0h expected 1", state_dbg); end
    checks++; if (dif.rf_read_addr1 !== 3'd1) begin errors++; $display("FAIL imm_hold_addr1: got %0d expected 1", dif.rf_read_addr1); end
    tick();
    idle();
    checks++; if (dif.ex_valid !== 1'b1) begin errors++; $display("FAIL imm_valid: got %0h expected 1", dif.ex_valid); end
    checks++; if (dif.ex_imm !== 16'h00FF) begin errors++; $display("FAIL imm_value: got %0h expected 00ff", dif.ex_imm); end
    checks++; if (dif.ex_use_imm !== 1'b1) begin errors++; $display("FAIL imm_use: got %0h expected 1", dif.ex_use_imm); end
    checks++; if (dif.ex_rdst !== 3'd1 || dif.ex_rsrc1 !== 3'd1) begin errors++; $display("FAIL imm_regs: got rdst=%0d rsrc1=%0d expected 1/1", dif.ex_rdst, dif.ex_rsrc1); end
    checks++; if (dif.ex_op1 !== 16'h0005 || dif.ex_op2 !== 16'h0010) begin errors++; $display("FAIL imm_ops: got %0h/%0h expected 0005/0010", dif.ex_op1, dif.ex_op2); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL imm_state_back: got %0h expected 0", state_dbg); end
  endtask

  task automatic test_load_use();
    send(16'h8400);
    tick();
    send(16'h4580);
    #1;
    checks++; if (dif.ex_mem_read !== 1'b1 || dif.ex_rdst !== 3'd4) begin errors++; $display("FAIL lu_load: got mem_read=%0h rdst=%0d expected 1/4", dif.ex_mem_read, dif.ex_rdst); end
    checks++; if (dif.ex_op1 !== 16'h0010) begin errors++; $display("FAIL lu_load_op1: got %0h expected 0010", dif.ex_op1); end
    checks++; if (dif.if_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_hazard: got %0h expected 0", dif.if_ready); end
    tick();
    checks++; if (dif.ex_valid !== 1'b0 || dif.ex_mem_read !== 1'b0) begin errors++; $display("FAIL lu_bubble: got valid=%0h mem_read=%0h expected 0/0", dif.ex_valid, dif.ex_mem_read); end
    checks++; if (dif.if_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_clear: got %0h expected 1", dif.if_ready); end
    tick();
    idle();
    checks++; if (dif.ex_valid !== 1'b1 || dif.ex_rdst !== 3'd5) begin errors++; $display("FAIL lu_issue: got valid=%0h rdst=%0d expected 1/5", dif.ex_valid, dif.ex_rdst); end
    checks++; if (dif.ex_op1 !== 16'h0044) begin errors++; $display("FAIL lu_issue_op1: got %0h expected 0044", dif.ex_op1); end
  endtask

  task automatic test_flush();
    send(16'h6120);
    tick();
    checks++; if (state_dbg !== 1'b1) begin errors++; $display("FAIL fl_state_wait: got %0h expected 1", state_dbg); end
    dif.flush = 1'b1;
    send(16'h4328);
    #1;
    checks++; if (dif.if_ready !== 1'b0) begin errors++; $display("FAIL fl_ready: got %0h expected 0", dif.if_ready); end
    tick();
    checks++; if (dif.ex_valid !== 1'b0 || state_dbg !== 1'b0) begin errors++; $display("FAIL fl_cleared: got valid=%0h state=%0h expected 0/0", dif.ex_valid, state_dbg); end
    dif.flush = 1'b0;
    tick();
    idle();
    checks++; if (dif.ex_valid !== 1'b1 || dif.ex_rdst !== 3'd3 || dif.ex_opcode !== 5'h08) begin errors++; $display("FAIL fl_fresh: got valid=%0h rdst=%0d opcode=%0h expected 1/3/08", dif.ex_valid, dif.ex_rdst, dif.ex_opcode); end
    checks++; if (dif.ex_use_imm !== 1'b0 || dif.ex_imm !== 16'h0000) begin errors++; $display("FAIL fl_no_imm: got use_imm=%0h imm=%0h expected 0/0", dif.ex_use_imm, dif.ex_imm); end
  endtask

  task automatic test_stall();
    send(16'h4328);
    tick();
    dif.ex_stall = 1'b1;
    send(16'h0A40);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dif.if_ready !== 1'b0) begin errors++; $display("FAIL st_ready_%0d: got %0h expected 0", i, dif.if_ready); end
      checks++; if (dif.ex_valid !== 1'b1 || dif.ex_rdst !== 3'd3) begin errors++; $display("FAIL st_hold_%0d: got valid=%0h rdst=%0d expected 1/3", i, dif.ex_valid, dif.ex_rdst); end
      checks++; if (dif.ex_op1 !== 16'h0005 || dif.ex_op2 !== 16'h0007) begin errors++; $display("FAIL st_ops_%0d: got %0h/%0h expected 0005/0007", i, dif.ex_op1, dif.ex_op2); end
      checks++; if (dif.rf_read_enable !== 1'b1 || dif.rf_read_addr1 !== 3'd2) begin errors++; $display("FAIL st_rf_%0d: got en=%0h addr1=%0d expected 1/2", i, dif.rf_read_enable, dif.rf_read_addr1); end
      @(posedge clk);
    end
    #1;
    dif.ex_stall = 1'b0;
    #1;
    checks++; if (dif.if_ready !== 1'b1) begin errors++; $display("FAIL st_release_ready: got %0h expected 1", dif.if_ready); end
    tick();
    idle();
    checks++; if (dif.ex_opcode !== 5'h01 || dif.ex_rdst !== 3'd2) begin errors++; $display("FAIL st_next: got opcode=%0h rdst=%0d expected 01/2", dif.ex_opcode, dif.ex_rdst); end
    checks++; if (dif.ex_op1 !== 16'h0007 || dif.ex_op2 !== 16'h0000) begin errors++; $display("FAIL st_next_ops: got %0h/%0h expected 0007/0000", dif.ex_op1, dif.ex_op2); end
    // flush overrides a simultaneous stall
    dif.ex_stall = 1'b1;
    dif.flush    = 1'b1;
    tick();
    checks++; if (dif.ex_valid !== 1'b0 || dif.ex_reg_write !== 1'b0) begin errors++; $display("FAIL st_flush_wins: got valid=%0h reg_write=%0h expected 0/0", dif.ex_valid, dif.ex_reg_write); end
    dif.ex_stall = 1'b0;
    dif.flush    = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words  [4];
    logic        rd_en  [4];
    logic [39:0] obs;
    logic [39:0] exp_v;
    words[0] = 16'h8828; rd_en[0] = 1'b1;   // store R1 -> [R2]... reads R1, R2
    words[1] = 16'hC060; rd_en[1] = 1'b1;   // branch on R3
    words[2] = 16'h0000; rd_en[2] = 1'b0;   // NOP
    words[3] = 16'h4328; rd_en[3] = 1'b1;   // ALU R1, R2 -> R3
    exp_q.push_back({5'h11, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0007});
    exp_q.push_back({5'h18, 1'b0, 1'b0, 1'b1, 16'h0033, 16'h0000});
    exp_q.push_back({5'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000});
    exp_q.push_back({5'h08, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0007});
    for (int i = 0; i < 4; i++) begin
      send(words[i]);
      #1;
      checks++; if (dif.rf_read_enable !== rd_en[i]) begin errors++; $display("FAIL b2b_rd_en_%0d: got %0h expected %0h", i, dif.rf_read_enable, rd_en[i]); end
      tick();
      exp_v = exp_q.pop_front();
      obs = {dif.ex_opcode, dif.ex_reg_write, dif.ex_mem_write, dif.ex_branch, dif.ex_op1, dif.ex_op2};
      checks++; if (dif.ex_valid !== 1'b1 || obs !== exp_v) begin errors++; $display("FAIL b2b_bundle_%0d: got valid=%0h bundle=%010h expected 1/%010h", i, dif.ex_valid, obs, exp_v); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    send(16'h4328);
    tick();
    send(16'h6120);
    tick();
    checks++; if (state_dbg !== 1'b1 || dif.ex_rdst !== 3'd3) begin errors++; $display("FAIL ar_pre: got state=%0h rdst=%0d expected 1/3", state_dbg, dif.ex_rdst); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (dif.ex_valid !== 1'b0 || dif.ex_rdst !== 3'd0 || dif.ex_opcode !== 5'h00) begin errors++; $display("FAIL ar_fields: got valid=%0h rdst=%0d opcode=%0h expected 0/0/0", dif.ex_valid, dif.ex_rdst, dif.ex_opcode); end
    checks++; if (dif.ex_op1 !== 16'h0000 || dif.ex_op2 !== 16'h0000) begin errors++; $display("FAIL ar_ops: got %0h/%0h expected 0/0", dif.ex_op1, dif.ex_op2); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL ar_state: got %0h expected 0", state_dbg); end
    rst = 1'b0;
    send(16'h4328);
    tick();
    idle();
    checks++; if (dif.ex_valid !== 1'b1 || dif.ex_use_imm !== 1'b0 || dif.ex_rdst !== 3'd3) begin errors++; $display("FAIL ar_fresh: got valid=%0h use_imm=%0h rdst=%0d expected 1/0/3", dif.ex_valid, dif.ex_use_imm, dif.ex_rdst); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    errors = 0;
    checks = 0;
    rf[0] = 16'h0010; rf[1] = 16'h0005; rf[2] = 16'h0007; rf[3] = 16'h0033;
    rf[4] = 16'h0044; rf[5] = 16'h0055; rf[6] = 16'h0066; rf[7] = 16'h0077;
    dif.rf_read_data1 = 16'h0000;
    dif.rf_read_data2 = 16'h0000;
    dif.flush    = 1'b0;
    dif.ex_stall = 1'b0;
    idle();
    rst = 1'b1;
    #12;
    test_reset();
    rst = 1'b0;
    tick();
    test_alu();
    test_imm();
    test_load_use();
    test_flush();
    test_stall();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
